// File: rtl/mult_sequencer_pkg.sv
// Shared types and constants for the multiply sequencer.
// State codes, multiply mode codes, word width and default timeout.
package mult_sequencer_pkg;

    localparam int WORD = 64;
    localparam int DEF_TIMEOUT = 80;

    localparam logic [1:0] MULT_LO = 2'b00;
    localparam logic [1:0] MULT_SH = 2'b01;
    localparam logic [1:0] MULT_UH = 2'b10;
    localparam logic [1:0] MULT_IL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_WB    = 3'd3,
        S_ABORT = 3'd4
    } state_t;

endpackage

// File: rtl/mult_sequencer_wait_counter.sv
// Saturating WAIT-cycle counter for the multiply sequencer.
// Flags expiry once TIMEOUT-1 further cycles have been counted.
module wait_counter #(
    parameter int TIMEOUT = 80
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && count != '1) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mult_sequencer.sv
// Sequences the iterative multiplier: start pulse, bounded wait,
// result capture and a one-cycle register write.
module mult_sequencer
    import mult_sequencer_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic            is_mult,
    input  logic [1:0]      mode_in,
    input  logic            mult_done,
    input  logic [WORD-1:0] mult_result,
    output logic            mult_start,
    output logic [1:0]      mult_mode,
    output logic            execute_result_loc,
    output logic            stall_pc,
    output logic            reg_write_en,
    output logic [WORD-1:0] result,
    output logic            busy,
    output logic            timeout_err,
    output logic            illegal_op
);

    state_t state;
    state_t next;
    logic   expired;
    logic   is_mul_op;
    logic   accept;
    logic   to_abort;

    assign is_mul_op = instr_valid & is_mult;
    assign accept    = is_mul_op & (mode_in != MULT_IL);
    assign to_abort  = (state == S_WAIT) & ~mult_done & expired;

    wait_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == S_START),
        .enable ((state == S_WAIT) & ~mult_done),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    // mult_done is only honoured in WAIT, so stale completions are dropped.
    always_comb begin
        next = state;
        unique case (state)
            S_IDLE:  if (accept) next = S_START;
            S_START: next = S_WAIT;
            S_WAIT: begin
                if (mult_done) begin
                    next = S_WB;
                end else if (expired) begin
                    next = S_ABORT;
                end
            end
            S_WB:    next = S_IDLE;
            S_ABORT: next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mult_mode   <= MULT_LO;
            result      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_IDLE && accept) begin
                mult_mode <= mode_in;
            end
            if (state == S_WAIT && mult_done) begin
                result <= mult_result;
            end
            if (to_abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

    always_comb begin
        mult_start         = 1'b0;
        execute_result_loc = 1'b0;
        stall_pc           = 1'b0;
        reg_write_en       = 1'b0;
        busy               = 1'b1;
        illegal_op         = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy       = 1'b0;
                stall_pc   = accept;
                illegal_op = is_mul_op & (mode_in == MULT_IL);
            end
            S_START: begin
                mult_start         = 1'b1;
                execute_result_loc = 1'b1;
                stall_pc           = 1'b1;
            end
            S_WAIT: begin
                execute_result_loc = 1'b1;
                stall_pc           = 1'b1;
            end
            S_WB: begin
                execute_result_loc = 1'b1;
                reg_write_en       = 1'b1;
            end
            S_ABORT: ;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: table rows, reset corner
// case and random operations against a cycle-count reference model.
module tb_mult_sequencer;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        is_mult;
    logic [1:0]  mode_in;
    logic        mult_done;
    logic [63:0] mult_result;
    logic        mult_start;
    logic [1:0]  mult_mode;
    logic        execute_result_loc;
    logic        stall_pc;
    logic        reg_write_en;
    logic [63:0] result;
    logic        busy;
    logic        timeout_err;
    logic        illegal_op;

    int checks = 0;
    int failures = 0;
    bit te_exp = 1'b0;

    always #5 clk = ~clk;

    mult_sequencer #(
        .TIMEOUT(TO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .instr_valid       (instr_valid),
        .is_mult           (is_mult),
        .mode_in           (mode_in),
        .mult_done         (mult_done),
        .mult_result       (mult_result),
        .mult_start        (mult_start),
        .mult_mode         (mult_mode),
        .execute_result_loc(execute_result_loc),
        .stall_pc          (stall_pc),
        .reg_write_en      (reg_write_en),
        .result            (result),
        .busy              (busy),
        .timeout_err       (timeout_err),
        .illegal_op        (illegal_op)
    );

    typedef struct {
        logic [1:0]  mode;
        int          d;
        logic [63:0] val;
        bit          early;
        int          e_stall;
        bit          e_write;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0;
        is_mult     = 1'b0;
        mode_in     = 2'b00;
        mult_done   = 1'b0;
        mult_result = '0;
    endtask

    // d = WAIT cycle on which done is raised (0 = never).
    // early raises a stale done in the accept and START cycles.
    task automatic run_op(input string tag, input logic [1:0] mode,
                          input int d, input logic [63:0] val,
                          input bit early, input int e_stall,
                          input bit e_write);
        int starts = 0;
        int stalls = 0;
        int writes = 0;
        int ills = 0;
        int wcyc = -1;
        int bad_mode = 0;
        int bad_eres = 0;
        int bad_busy = 0;
        logic [63:0] wval = '0;
        bit legal = (mode != 2'b11);
        bit eres;
        for (int c = 0; c <= e_stall; c++) begin
            @(posedge clk);
            #1;
            instr_valid = (c == 0);
            is_mult     = (c == 0);
            mode_in     = (c == 0) ? mode : 2'($urandom);
            mult_done   = (early && c <= 1) || (d > 0 && c == 1 + d);
            mult_result = (d > 0 && c == 1 + d) ? val
                                                : {$urandom, $urandom};
            @(negedge clk);
            starts += int'(mult_start);
            stalls += int'(stall_pc);
            ills   += int'(illegal_op);
            if (reg_write_en) begin
                writes++;
                wcyc = c;
                wval = result;
            end
            if (busy !== (legal && c > 0)) bad_busy++;
            if (legal && c > 0 && mult_mode !== mode) bad_mode++;
            eres = legal && c > 0 && (c < e_stall || e_write);
            if (execute_result_loc !== eres) bad_eres++;
        end
        if (legal && !e_write) te_exp = 1'b1;
        check({tag, "_start"}, 64'(starts), legal ? 64'd1 : 64'd0);
        check({tag, "_stall"}, 64'(stalls), 64'(e_stall));
        check({tag, "_write"}, 64'(writes), 64'(e_write));
        check({tag, "_illegal"}, 64'(ills), legal ? 64'd0 : 64'd1);
        check({tag, "_busy"}, 64'(bad_busy), 64'd0);
        check({tag, "_eres"}, 64'(bad_eres), 64'd0);
        check({tag, "_timeout"}, 64'(timeout_err), 64'(te_exp));
        if (legal) check({tag, "_mode"}, 64'(bad_mode), 64'd0);
        if (e_write) begin
            check({tag, "_wval"}, wval, val);
            check({tag, "_wcyc"}, 64'(wcyc), 64'(e_stall));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_stall"}, 64'(stall_pc), 64'd0);
        check({tag, "_start"}, 64'(mult_start), 64'd0);
        check({tag, "_write"}, 64'(reg_write_en), 64'd0);
        check({tag, "_eres"}, 64'(execute_result_loc), 64'd0);
        check({tag, "_te"}, 64'(timeout_err), 64'd0);
        check({tag, "_ill"}, 64'(illegal_op), 64'd0);
        check({tag, "_mode"}, 64'(mult_mode), 64'd0);
        check({tag, "_result"}, result, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int writes;
        int busies;
        logic [1:0] m;
        int d;
        bit legal;
        bit done;
        int eff;

        tbl[0] = '{2'b00, 5, 64'h2A, 1'b0, 7, 1'b1};
        tbl[1] = '{2'b10, 0, 64'h0, 1'b0, 2 + TO, 1'b0};
        tbl[2] = '{2'b11, 0, 64'h0, 1'b0, 0, 1'b0};
        tbl[3] = '{2'b00, 3, 64'h1234_5678_9ABC_DEF0, 1'b1, 5, 1'b1};
        tbl[4] = '{2'b01, 1, 64'h1, 1'b0, 3, 1'b1};
        tbl[5] = '{2'b01, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3, 1'b1};
        tbl[6] = '{2'b01, TO, 64'hDEAD_BEEF_0000_0001, 1'b0, 2 + TO, 1'b1};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("row%0d", i), tbl[i].mode, tbl[i].d,
                   tbl[i].val, tbl[i].early, tbl[i].e_stall,
                   tbl[i].e_write);
        end

        // Reset on the second WAIT cycle of a MUL.
        writes = 0;
        busies = 0;
        for (int c = 0; c <= 8; c++) begin
            @(posedge clk);
            #1;
            instr_valid = (c == 0);
            is_mult     = (c == 0);
            mode_in     = (c == 0) ? 2'b10 : 2'b00;
            reset       = (c == 3);
            mult_done   = (c == 5);
            mult_result = 64'h5555;
            @(negedge clk);
            if (c == 4) check_reset_outputs("midreset");
            if (c >= 4) begin
                writes += int'(reg_write_en);
                busies += int'(busy);
            end
        end
        te_exp = 1'b0;
        check("midreset_late_write", 64'(writes), 64'd0);
        check("midreset_late_busy", 64'(busies), 64'd0);

        for (int i = 0; i < 24; i++) begin
            m     = 2'($urandom_range(0, 3));
            d     = $urandom_range(0, TO + 1);
            legal = (m != 2'b11);
            done  = (d >= 1 && d <= TO);
            eff   = done ? d : TO;
            run_op($sformatf("rnd%0d", i), m, d, {$urandom, $urandom},
                   1'($urandom), legal ? 2 + eff : 0, legal && done);
        end

        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        check("drain_busy", 64'(busy), 64'd0);
        check("drain_stall", 64'(stall_pc), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
